// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, grant IDs and defaults for the RAM2 two-master arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: 8-bit busy-cycle counter that flags when a RAM2 access has run for TIMEOUT cycles.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 8'd1;
  end
  // Fires in the TIMEOUT-th busy cycle so the abort lands on that cycle's edge.
  assign o_expired = i_inc && (r_cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin merge of fetch and load/store ports onto RAM2 with registered RAM-side outputs.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err
);
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must fit the 8-bit watchdog counter");
  end
  state_t r_state, n_state;
  logic r_last, n_last;
  logic r_m_re, n_m_re, r_m_we, n_m_we;
  logic [ADDR_W-1:0] r_m_addr, n_m_addr;
  logic [DATA_W-1:0] r_m_wdata, n_m_wdata;
  logic [DATA_W-1:0] r_i_rdata, n_i_rdata, r_d_rdata, n_d_rdata;
  logic r_i_ready, n_i_ready, r_d_ready, n_d_ready, r_err, n_err;
  logic w_d_req, w_gnt_i, w_gnt_d, w_expired;
  assign w_d_req = d_re | d_we;
  // Data wins only when fetch is idle or fetch was served last.
  assign w_gnt_d = w_d_req && (!i_re || r_last == PORT_I);
  assign w_gnt_i = i_re && !w_gnt_d;
`ifdef MEM_ARB_TIMEOUT_EN
  logic w_busy;
  assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);
  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state == IDLE),
    .i_inc    (w_busy),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif
  always_comb begin
    n_state   = r_state;
    n_last    = r_last;
    n_m_re    = r_m_re;
    n_m_we    = r_m_we;
    n_m_addr  = r_m_addr;
    n_m_wdata = r_m_wdata;
    n_i_rdata = r_i_rdata;
    n_d_rdata = r_d_rdata;
    n_i_ready = 1'b0;
    n_d_ready = 1'b0;
    n_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_i) begin
          n_state  = BUSY_I;
          n_last   = PORT_I;
          n_m_re   = 1'b1;
          n_m_we   = 1'b0;
          n_m_addr = i_addr;
        end else if (w_gnt_d) begin
          n_state   = BUSY_D;
          n_last    = PORT_D;
          n_m_re    = !d_we;
          n_m_we    = d_we;
          n_m_addr  = d_addr;
          n_m_wdata = d_wdata;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ready || w_expired) begin
          n_state = DONE;
          n_m_re  = 1'b0;
          n_m_we  = 1'b0;
          n_err   = !m_ready;
          if (r_state == BUSY_I) begin
            n_i_ready = 1'b1;
            n_i_rdata = m_ready ? m_rdata : DATA_W'(TIMEOUT_RDATA);
          end else begin
            n_d_ready = 1'b1;
            n_d_rdata = !r_m_re ? r_d_rdata : m_ready ? m_rdata : DATA_W'(TIMEOUT_RDATA);
          end
        end
      end
      default: n_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_last    <= PORT_D;
      r_m_re    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= n_state;
      r_last    <= n_last;
      r_m_re    <= n_m_re;
      r_m_we    <= n_m_we;
      r_m_addr  <= n_m_addr;
      r_m_wdata <= n_m_wdata;
      r_i_rdata <= n_i_rdata;
      r_d_rdata <= n_d_rdata;
      r_i_ready <= n_i_ready;
      r_d_ready <= n_d_ready;
      r_err     <= n_err;
    end
  end
  assign m_re    = r_m_re;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign i_ready = r_i_ready;
  assign d_ready = r_d_ready;
  assign err     = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for reset-in-flight and watchdog abort.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_re = 1'b0, d_re = 1'b0, d_we = 1'b0, m_ready = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic i_ready, d_ready, m_re, m_we, err;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  typedef struct {
    logic ire; logic [15:0] ia; logic dre; logic dwe; logic [15:0] da; logic [15:0] dw;
    logic [15:0] mrd; logic mrdy;
    logic ere; logic ewe; logic [15:0] ea; logic [15:0] ew;
    logic eir; logic [15:0] eird; logic edr; logic [15:0] edrd;
  } vec_t;
  vec_t v[30];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ire, input logic [15:0] ia, input logic dre, input logic dwe,
                       input logic [15:0] da, input logic [15:0] dw, input logic [15:0] mrd,
                       input logic mrdy);
    i_re = ire; i_addr = ia; d_re = dre; d_we = dwe;
    d_addr = da; d_wdata = dw; m_rdata = mrd; m_ready = mrdy;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " m_re"}, {31'd0, m_re}, 0);
    chk({tag, " m_we"}, {31'd0, m_we}, 0);
    chk({tag, " m_addr"}, {16'd0, m_addr}, 0);
    chk({tag, " m_wdata"}, {16'd0, m_wdata}, 0);
    chk({tag, " i_rdata"}, {16'd0, i_rdata}, 0);
    chk({tag, " d_rdata"}, {16'd0, d_rdata}, 0);
    chk({tag, " i_ready"}, {31'd0, i_ready}, 0);
    chk({tag, " d_ready"}, {31'd0, d_ready}, 0);
    chk({tag, " err"}, {31'd0, err}, 0);
  endtask

  initial begin
    // ire ia dre dwe da dw mrd mrdy | ere ewe ea ew eir eird edr edrd
    v[0]  = '{1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 16'h0001, 16'h0000, 0, 16'h0000, 0, 16'h0000};
    v[1]  = '{1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 16'h0001, 16'h0000, 0, 16'h0000, 0, 16'h0000};
    v[2]  = '{1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 16'h3434, 1, 0, 0, 16'h0001, 16'h0000, 1, 16'h3434, 0, 16'h0000};
    v[3]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0001, 16'h0000, 0, 16'h3434, 0, 16'h0000};
    v[4]  = '{0, 16'h0000, 0, 1, 16'hABCD, 16'h5656, 16'h0000, 0, 0, 1, 16'hABCD, 16'h5656, 0, 16'h3434, 0, 16'h0000};
    v[5]  = '{0, 16'h0000, 0, 1, 16'hABCD, 16'h5656, 16'h0000, 0, 0, 1, 16'hABCD, 16'h5656, 0, 16'h3434, 0, 16'h0000};
    v[6]  = '{0, 16'h0000, 0, 1, 16'hABCD, 16'h5656, 16'hDEAD, 1, 0, 0, 16'hABCD, 16'h5656, 0, 16'h3434, 1, 16'h0000};
    v[7]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'hABCD, 16'h5656, 0, 16'h3434, 0, 16'h0000};
    v[8]  = '{1, 16'hABCD, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 16'hABCD, 16'h5656, 0, 16'h3434, 0, 16'h0000};
    v[9]  = '{1, 16'hABCD, 0, 0, 16'h0000, 16'h0000, 16'h5656, 1, 0, 0, 16'hABCD, 16'h5656, 1, 16'h5656, 0, 16'h0000};
    v[10] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'hABCD, 16'h5656, 0, 16'h5656, 0, 16'h0000};
    v[11] = '{1, 16'h0002, 1, 0, 16'h0003, 16'h0000, 16'h0000, 0, 1, 0, 16'h0003, 16'h0000, 0, 16'h5656, 0, 16'h0000};
    v[12] = '{1, 16'h0002, 1, 0, 16'h0003, 16'h0000, 16'h1111, 1, 0, 0, 16'h0003, 16'h0000, 0, 16'h5656, 1, 16'h1111};
    v[13] = '{1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0003, 16'h0000, 0, 16'h5656, 0, 16'h1111};
    v[14] = '{1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 16'h0002, 16'h0000, 0, 16'h5656, 0, 16'h1111};
    v[15] = '{1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 16'h2222, 1, 0, 0, 16'h0002, 16'h0000, 1, 16'h2222, 0, 16'h1111};
    v[16] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0002, 16'h0000, 0, 16'h2222, 0, 16'h1111};
    v[17] = '{1, 16'h0004, 1, 0, 16'h0005, 16'h0000, 16'h0000, 0, 1, 0, 16'h0005, 16'h0000, 0, 16'h2222, 0, 16'h1111};
    v[18] = '{1, 16'h0004, 1, 0, 16'h0005, 16'h0000, 16'h5555, 1, 0, 0, 16'h0005, 16'h0000, 0, 16'h2222, 1, 16'h5555};
    v[19] = '{1, 16'h0004, 1, 0, 16'h0005, 16'h0000, 16'h0000, 0, 0, 0, 16'h0005, 16'h0000, 0, 16'h2222, 0, 16'h5555};
    v[20] = '{1, 16'h0004, 1, 0, 16'h0005, 16'h0000, 16'h0000, 0, 1, 0, 16'h0004, 16'h0000, 0, 16'h2222, 0, 16'h5555};
    v[21] = '{1, 16'h0004, 1, 0, 16'h0005, 16'h0000, 16'h4444, 1, 0, 0, 16'h0004, 16'h0000, 1, 16'h4444, 0, 16'h5555};
    v[22] = '{1, 16'h0004, 1, 0, 16'h0005, 16'h0000, 16'h0000, 0, 0, 0, 16'h0004, 16'h0000, 0, 16'h4444, 0, 16'h5555};
    v[23] = '{1, 16'h0004, 1, 0, 16'h0005, 16'h0000, 16'h0000, 0, 1, 0, 16'h0005, 16'h0000, 0, 16'h4444, 0, 16'h5555};
    v[24] = '{1, 16'h0004, 1, 0, 16'h0005, 16'h0000, 16'h6666, 1, 0, 0, 16'h0005, 16'h0000, 0, 16'h4444, 1, 16'h6666};
    v[25] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0005, 16'h0000, 0, 16'h4444, 0, 16'h6666};
    v[26] = '{0, 16'h0000, 1, 1, 16'h0000, 16'h1212, 16'h0000, 0, 0, 1, 16'h0000, 16'h1212, 0, 16'h4444, 0, 16'h6666};
    v[27] = '{0, 16'h0000, 1, 1, 16'h0000, 16'h1212, 16'h9999, 1, 0, 0, 16'h0000, 16'h1212, 0, 16'h4444, 1, 16'h6666};
    v[28] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 16'h1212, 0, 16'h4444, 0, 16'h6666};
    v[29] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 16'h1212, 0, 16'h4444, 0, 16'h6666};

    step();
    step();
    chk_all_zero("reset");
    rst = 1'b1;
    step();

    for (int k = 0; k < 30; k++) begin
      drive(v[k].ire, v[k].ia, v[k].dre, v[k].dwe, v[k].da, v[k].dw, v[k].mrd, v[k].mrdy);
      step();
      chk($sformatf("v%0d m_re", k), {31'd0, m_re}, {31'd0, v[k].ere});
      chk($sformatf("v%0d m_we", k), {31'd0, m_we}, {31'd0, v[k].ewe});
      chk($sformatf("v%0d m_addr", k), {16'd0, m_addr}, {16'd0, v[k].ea});
      chk($sformatf("v%0d m_wdata", k), {16'd0, m_wdata}, {16'd0, v[k].ew});
      chk($sformatf("v%0d i_ready", k), {31'd0, i_ready}, {31'd0, v[k].eir});
      chk($sformatf("v%0d i_rdata", k), {16'd0, i_rdata}, {16'd0, v[k].eird});
      chk($sformatf("v%0d d_ready", k), {31'd0, d_ready}, {31'd0, v[k].edr});
      chk($sformatf("v%0d d_rdata", k), {16'd0, d_rdata}, {16'd0, v[k].edrd});
      chk($sformatf("v%0d err", k), {31'd0, err}, 0);
    end

    // Reset while a data read is in flight, then a tie must go to fetch first.
    drive(0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 16'h0000, 0);
    step();
    chk("midrst busy m_re", {31'd0, m_re}, 1);
    chk("midrst busy m_addr", {16'd0, m_addr}, 32'h0010);
    #3;
    rst = 1'b0;
    d_re = 1'b0;
    #1;
    chk_all_zero("async rst");
    step();
    chk_all_zero("held rst");
    #3;
    rst = 1'b1;
    drive(1, 16'h0020, 1, 0, 16'h0021, 16'h0000, 16'h0000, 0);
    step();
    chk("post rst tie m_re", {31'd0, m_re}, 1);
    chk("post rst tie m_addr", {16'd0, m_addr}, 32'h0020);
    drive(1, 16'h0020, 1, 0, 16'h0021, 16'h0000, 16'h7777, 1);
    step();
    chk("post rst i_ready", {31'd0, i_ready}, 1);
    chk("post rst i_rdata", {16'd0, i_rdata}, 32'h7777);
    chk("post rst d_ready", {31'd0, d_ready}, 0);
    drive(0, 16'h0000, 1, 0, 16'h0021, 16'h0000, 16'h0000, 0);
    step();
    step();
    chk("second d m_re", {31'd0, m_re}, 1);
    chk("second d m_addr", {16'd0, m_addr}, 32'h0021);
    drive(0, 16'h0000, 1, 0, 16'h0021, 16'h0000, 16'h7878, 1);
    step();
    chk("second d d_ready", {31'd0, d_ready}, 1);
    chk("second d d_rdata", {16'd0, d_rdata}, 32'h7878);
    drive(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    step();
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // RAM never answers: abort after four busy cycles.
    drive(1, 16'h0030, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    step();
    chk("to grant m_re", {31'd0, m_re}, 1);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("to wait%0d i_ready", k), {31'd0, i_ready}, 0);
      chk($sformatf("to wait%0d err", k), {31'd0, err}, 0);
      chk($sformatf("to wait%0d m_re", k), {31'd0, m_re}, 1);
    end
    i_re = 1'b0;
    step();
    chk("to i_ready", {31'd0, i_ready}, 1);
    chk("to i_rdata", {16'd0, i_rdata}, 32'hFFFF);
    chk("to err", {31'd0, err}, 1);
    chk("to m_re drop", {31'd0, m_re}, 0);
    step();
    chk("to err pulse end", {31'd0, err}, 0);
    chk("to i_ready end", {31'd0, i_ready}, 0);
    drive(1, 16'h0031, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    step();
    chk("after to m_re", {31'd0, m_re}, 1);
    chk("after to m_addr", {16'd0, m_addr}, 32'h0031);
    drive(1, 16'h0031, 0, 0, 16'h0000, 16'h0000, 16'h8888, 1);
    step();
    chk("after to i_ready", {31'd0, i_ready}, 1);
    chk("after to i_rdata", {16'd0, i_rdata}, 32'h8888);
    chk("after to err", {31'd0, err}, 0);
    drive(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter upstream of the RAM2 data memory. It merges the instruction-fetch port (read-only) and the load/store port (read/write) onto RAM2's single re/we/addr/wdata/rdata/ready interface. Round-robin grant, registered RAM-side outputs, and a one-cycle ready pulse back to the winning master.

Parameters:
ADDR_W, 16, address width (matches RAM2 addr)
DATA_W, 16, data width (matches RAM2 wdata/rdata)
TIMEOUT, 255, watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN); counter is 8 bits

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-low reset
i_re  in  1  fetch read request, held until i_ready
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetch read data, valid when i_ready=1
i_ready  out  1  fetch completion pulse (1 cycle)
d_re  in  1  data read request, held until d_ready
d_we  in  1  data write request, held until d_ready
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  data read data, valid when d_ready=1
d_ready  out  1  data completion pulse (1 cycle)
m_re  out  1  to RAM2 re
m_we  out  1  to RAM2 we
m_addr  out  ADDR_W  to RAM2 addr
m_wdata  out  DATA_W  to RAM2 wdata
m_rdata  in  DATA_W  from RAM2 rdata
m_ready  in  1  from RAM2 ready; rdata valid and write committed in this cycle
err  out  1  timeout pulse (1 cycle); constant 0 without the macro

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; last_grant=D (so fetch wins the first tie).
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: sample requests at the edge. One pending request: grant it. Both pending: grant the port not in last_grant. Capture addr/wdata into the m_* registers. Assert m_re (or m_we), update last_grant.
- d_re and d_we both 1: treated as a write; m_re=0.
- BUSY_x: m_* held stable. When m_ready=1 at an edge:
  - capture m_rdata into x_rdata
  - x_ready=1 for exactly the next cycle
  - m_re/m_we drop to 0
  - go to DONE
- DONE: one cycle. Requests are ignored so the master can deassert, then go to IDLE. Back-to-back requests from the same master are therefore spaced by at least one idle cycle.
- Latency: RAM wait cycles + 2 (grant edge, completion edge). Minimum request-to-ready is 3 cycles when RAM answers in 1.
- x_rdata holds its value until the next completion on that port. It is undefined for writes; writes leave it unchanged.
- Requests arriving while BUSY/DONE wait in IDLE arbitration. No queueing beyond the level-held request.
- Master deasserts mid-transaction: the transaction completes anyway and the ready pulse is still issued.
- m_ready while IDLE/DONE: ignored.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Enabled: an 8-bit counter clears on grant and increments each BUSY cycle. When it reaches TIMEOUT without m_ready:
  - drop m_re/m_we
  - x_rdata=16'hFFFF, x_ready pulse
  - err=1 for one cycle
  - go to DONE
- Disabled: BUSY waits indefinitely; err tied 0; no counter logic.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY_I, BUSY_D, DONE), grant-ID constants PORT_I/PORT_D, ADDR_W/DATA_W defaults, TIMEOUT_RDATA=16'hFFFF.
- Sub-module mem_arb_watchdog: counter plus expiry flag; instantiated only under the macro. FSM and datapath stay in the top.

Test Plan:
- Reset, then fetch read of 0x0001 with the RAM returning 0x3434 after 2 cycles -> m_re=1 with m_addr=0001; i_ready pulses once with i_rdata=3434; d_ready stays 0.
- Data write 0xABCD<=0x5656 -> m_we=1, m_wdata=5656 until m_ready; d_ready pulse; readback via fetch returns 5656.
- i_re and d_re raised in the same cycle after reset -> fetch granted first, data second. Repeat the tie -> data first (alternation).
- d_re=d_we=1 at 0x0000 with wdata 0x1212 -> write performed, m_re never 1.
- rst=0 asserted mid-BUSY_D -> all outputs 0 immediately; after release IDLE; a fresh request is served normally.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=4, RAM never ready -> after 4 BUSY cycles i_ready=1, i_rdata=FFFF, err=1 for one cycle; the next request is served.
